// File: rtl/bcd_to_bin_serial_pkg.sv
// Shared constants and state encoding for the serial BCD-to-binary converter.
package bcd_to_bin_serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [3:0] BCD_MAX_DIGIT  = 4'd9;
    localparam logic [3:0] BCD_ADJ_THRESH = 4'd8;
    localparam logic [3:0] BCD_ADJ_SUB    = 4'd3;

endpackage

// File: rtl/bcd_to_bin_serial_if.sv
// Start/busy/done handshake and data bus of the BCD-to-binary converter.
interface bcd_to_bin_serial_if #(
    parameter int unsigned DIGITS = 3,
    parameter int unsigned BIN_W  = 10
);

    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [BIN_W-1:0]      bin_out;

    modport master (
        output start,
        output bcd_in,
        input  busy,
        input  done,
        input  err,
        input  bin_out
    );

    modport slave (
        input  start,
        input  bcd_in,
        output busy,
        output done,
        output err,
        output bin_out
    );

endinterface

// File: rtl/bcd_digit_adjust.sv
// One BCD digit correction for reverse double-dabble: digits >= 8 lose 3 after each shift.
module bcd_digit_adjust
    import bcd_to_bin_serial_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    assign digit_o = (digit_i >= BCD_ADJ_THRESH) ? (digit_i - BCD_ADJ_SUB) : digit_i;

endmodule

// File: rtl/bcd_to_bin_serial.sv
// Serial BCD-to-binary converter: one reverse double-dabble shift/correct step per clock.
module bcd_to_bin_serial
    import bcd_to_bin_serial_pkg::*;
#(
    parameter int unsigned DIGITS = 3,
    parameter int unsigned BIN_W  = 10
) (
    input logic                clk,
    input logic                rst_n,
    bcd_to_bin_serial_if.slave bus
);

    localparam int unsigned SR_W  = 4 * DIGITS + BIN_W;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    state_e             state_q, state_d;
    logic [SR_W-1:0]    sr_q, sr_d;
    logic [SR_W-1:0]    sr_shift, sr_adj;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic               err_q, err_d;
    logic               bad_digit;

    assign sr_shift = sr_q >> 1;

    // Binary bits pass through; each BCD field is corrected after the shift.
    assign sr_adj[BIN_W-1:0] = sr_shift[BIN_W-1:0];

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit_i (sr_shift[BIN_W + 4*g +: 4]),
            .digit_o (sr_adj[BIN_W + 4*g +: 4])
        );
    end

    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.bcd_in[4*i +: 4] > BCD_MAX_DIGIT) begin
                bad_digit = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bad_digit) begin
                        bin_d   = '0;
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        sr_d    = {bus.bcd_in, {BIN_W{1'b0}}};
                        cnt_d   = '0;
                        err_d   = 1'b0;
                        state_d = ST_CONV;
                    end
                end
            end
            ST_CONV: begin
                sr_d  = sr_adj;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    bin_d   = sr_adj[BIN_W-1:0];
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            bin_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            err_q   <= err_d;
        end
    end

    assign bus.busy    = (state_q == ST_CONV);
    assign bus.done    = (state_q == ST_DONE);
    assign bus.err     = err_q;
    assign bus.bin_out = bin_q;

endmodule

// File: tb/tb_bcd_to_bin_serial.sv
// Self-checking bench for bcd_to_bin_serial against a decimal-arithmetic reference model.
module tb_bcd_to_bin_serial;

    localparam int DIGITS = 3;
    localparam int BIN_W  = 10;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;
    int   cyc;

    bcd_to_bin_serial_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

    bcd_to_bin_serial #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: weighted decimal sum; any digit above 9 is an error with result 0.
    function automatic void ref_conv(input logic [11:0] bcd, output int val, output bit bad);
        int w;
        logic [3:0] d;
        val = 0;
        bad = 0;
        w   = 1;
        for (int i = 0; i < DIGITS; i++) begin
            d = bcd[4*i +: 4];
            if (d > 4'd9) bad = 1;
            val = val + int'(d) * w;
            w   = w * 10;
        end
        if (bad) val = 0;
    endfunction

    function automatic logic [11:0] to_bcd(input int v);
        logic [11:0] r;
        r[3:0]  = 4'(v % 10);
        r[7:4]  = 4'((v / 10) % 10);
        r[11:8] = 4'((v / 100) % 10);
        return r;
    endfunction

    // Drives one start pulse and observes the handshake; lat is the cycle index of done
    // counted from 1 for the cycle after the start edge, -1 if done never came.
    task automatic do_conv(input logic [11:0] bcd, output int busy_cnt, output int lat,
                           output logic [BIN_W-1:0] bin, output logic e, output logic done_after);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bcd_in = bcd;
        @(negedge clk);
        bus.start = 1'b0;
        busy_cnt  = 0;
        lat       = -1;
        bin       = 'x;
        e         = 1'bx;
        done_after = 1'bx;
        for (int n = 1; n <= 40; n++) begin
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.done === 1'b1) begin
                lat = n;
                bin = bus.bin_out;
                e   = bus.err;
                @(negedge clk);
                done_after = bus.done;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n      = 1'b0;
        bus.start  = 1'b1;
        bus.bcd_in = 12'h999;
        #1;
        tests_run++;
        if ({bus.busy, bus.done, bus.err, bus.bin_out} !== 13'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got busy=%b done=%b err=%b bin=%0d want all 0",
                     bus.busy, bus.done, bus.err, bus.bin_out);
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_start_ignored: busy=%b want 0", bus.busy);
        end
        bus.start = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int bc, lat, exp_v;
        bit bad;
        logic [BIN_W-1:0] bin;
        logic e, da;
        do_conv(12'h999, bc, lat, bin, e, da);
        ref_conv(12'h999, exp_v, bad);
        tests_run++;
        if (lat !== 11) begin
            tests_failed++;
            $display("FAIL basic_latency: done at cycle %0d want 11", lat);
        end
        tests_run++;
        if (bc !== 10) begin
            tests_failed++;
            $display("FAIL basic_busy_cycles: got %0d want 10", bc);
        end
        tests_run++;
        if (bin !== BIN_W'(exp_v) || e !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_result: got bin=%0d err=%b want bin=%0d err=0", bin, e, exp_v);
        end
        tests_run++;
        if (da !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_done_width: done after pulse=%b want 0", da);
        end
    endtask

    task automatic test_values;
        logic [11:0] vals[$];
        int bc, lat, exp_v;
        bit bad;
        logic [BIN_W-1:0] bin;
        logic e, da;
        vals = '{12'h255, 12'h015, 12'h000};
        for (int i = 0; i < 20; i++) vals.push_back(to_bcd(int'($urandom_range(0, 999))));
        foreach (vals[i]) begin
            do_conv(vals[i], bc, lat, bin, e, da);
            ref_conv(vals[i], exp_v, bad);
            tests_run++;
            if (lat !== 11 || da !== 1'b0 || bin !== BIN_W'(exp_v) || e !== 1'b0) begin
                tests_failed++;
                $display("FAIL value_%03h: got lat=%0d done_after=%b bin=%0d err=%b want lat=11 done_after=0 bin=%0d err=0",
                         vals[i], lat, da, bin, e, exp_v);
            end
        end
    endtask

    task automatic test_invalid;
        logic [11:0] vals[$];
        logic [11:0] r;
        int bc, lat, exp_v;
        bit bad;
        logic [BIN_W-1:0] bin;
        logic e, da;
        vals = '{12'h1A3};
        for (int i = 0; i < 8; i++) begin
            r = 12'($urandom);
            r[4*(i%3) +: 4] = 4'($urandom_range(10, 15));
            vals.push_back(r);
        end
        foreach (vals[i]) begin
            do_conv(vals[i], bc, lat, bin, e, da);
            ref_conv(vals[i], exp_v, bad);
            tests_run++;
            if (lat !== 1 || bc !== 0 || da !== 1'b0 || bin !== BIN_W'(exp_v) || e !== bad) begin
                tests_failed++;
                $display("FAIL invalid_%03h: got lat=%0d busy=%0d bin=%0d err=%b want lat=1 busy=0 bin=%0d err=%b",
                         vals[i], lat, bc, bin, e, exp_v, bad);
            end
        end
        // err must clear as soon as a valid start is accepted
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bcd_in = 12'h042;
        @(negedge clk);
        bus.start = 1'b0;
        tests_run++;
        if (bus.err !== 1'b0 || bus.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL invalid_err_clear: got err=%b busy=%b want err=0 busy=1", bus.err, bus.busy);
        end
        lat = -1;
        for (int n = 0; n < 30; n++) begin
            if (bus.done === 1'b1) begin
                lat = n;
                break;
            end
            @(negedge clk);
        end
        tests_run++;
        if (lat < 0 || bus.bin_out !== BIN_W'(42) || bus.err !== 1'b0) begin
            tests_failed++;
            $display("FAIL invalid_then_valid: got bin=%0d err=%b timeout=%0d want bin=42 err=0",
                     bus.bin_out, bus.err, lat < 0);
        end
        @(negedge clk);
    endtask

    task automatic test_ignore_start;
        int dones;
        logic [BIN_W-1:0] last_bin;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bcd_in = 12'h123;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        bus.start  = 1'b1;
        bus.bcd_in = 12'h777;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.bcd_in = 12'h999;
        dones    = 0;
        last_bin = '0;
        for (int n = 0; n < 30; n++) begin
            if (bus.done === 1'b1) begin
                dones++;
                last_bin = bus.bin_out;
            end
            @(negedge clk);
        end
        tests_run++;
        if (dones !== 1) begin
            tests_failed++;
            $display("FAIL ignore_start_dones: got %0d want 1", dones);
        end
        tests_run++;
        if (last_bin !== BIN_W'(123)) begin
            tests_failed++;
            $display("FAIL ignore_start_result: got %0d want 123", last_bin);
        end
    endtask

    task automatic test_reset_abort;
        int bc, lat, dones;
        logic [BIN_W-1:0] bin;
        logic e, da;
        // Leave a non-zero result behind so the reset clear is visible.
        do_conv(12'h042, bc, lat, bin, e, da);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bcd_in = 12'h500;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({bus.busy, bus.done, bus.err, bus.bin_out} !== 13'd0) begin
            tests_failed++;
            $display("FAIL abort_clear: got busy=%b done=%b err=%b bin=%0d want all 0",
                     bus.busy, bus.done, bus.err, bus.bin_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int n = 0; n < 20; n++) begin
            if (bus.done === 1'b1) dones++;
            @(negedge clk);
        end
        tests_run++;
        if (dones !== 0) begin
            tests_failed++;
            $display("FAIL abort_no_done: got %0d dones want 0", dones);
        end
        do_conv(12'h500, bc, lat, bin, e, da);
        tests_run++;
        if (lat !== 11 || bin !== BIN_W'(500) || e !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_reconvert: got lat=%0d bin=%0d err=%b want lat=11 bin=500 err=0",
                     lat, bin, e);
        end
    endtask

    task automatic test_back_to_back;
        int last_cyc, n;
        @(negedge clk);
        bus.bcd_in = to_bcd(0);
        bus.start  = 1'b1;
        last_cyc   = -1;
        for (int v = 0; v < 1000; v++) begin
            n = 0;
            while (bus.done !== 1'b1 && n < 30) begin
                @(negedge clk);
                n++;
            end
            tests_run++;
            if (n >= 30) begin
                tests_failed++;
                $display("FAIL sweep_timeout: no done for value %0d", v);
                break;
            end
            if (bus.bin_out !== BIN_W'(v) || bus.err !== 1'b0) begin
                tests_failed++;
                $display("FAIL sweep_value_%0d: got bin=%0d err=%b want bin=%0d err=0",
                         v, bus.bin_out, bus.err, v);
            end
            if (last_cyc >= 0) begin
                tests_run++;
                if (cyc - last_cyc !== 12) begin
                    tests_failed++;
                    $display("FAIL sweep_spacing_%0d: got %0d cycles want 12", v, cyc - last_cyc);
                end
            end
            last_cyc   = cyc;
            bus.bcd_in = to_bcd((v + 1) % 1000);
            @(negedge clk);
        end
        bus.start = 1'b0;
        repeat (15) @(negedge clk);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        bus.start    = 1'b0;
        bus.bcd_in   = '0;
        test_reset();
        test_basic();
        test_values();
        test_invalid();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
